// File: rtl/ucsbece154a_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154a_datapath_pkg
// Description : Control-bus encodings shared by the multicycle RV32I
//               controller and datapath, plus the immediate extender.
// Revision    : 1.0 - initial release
// ============================================================================
package ucsbece154a_datapath_pkg;

  // ALU operation select
  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  // Immediate format select
  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  // ALU source A select
  localparam logic [1:0] c_SRCA_PC    = 2'b00;
  localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] c_SRCA_A     = 2'b10;

  // ALU source B select
  localparam logic [1:0] c_SRCB_B    = 2'b00;
  localparam logic [1:0] c_SRCB_IMM  = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_DATA   = 2'b01;
  localparam logic [1:0] c_RES_ALURES = 2'b10;
  localparam logic [1:0] c_RES_IMM    = 2'b11;

  // Sign/zero extends the immediate field of an instruction; the opcode bits
  // never contribute, so only bits [31:7] are taken.
  function automatic logic [31:0] imm_extend(input logic [31:7] i, input logic [2:0] imm_src);
    logic [31:0] imm;
    imm = 32'd0;
    case (imm_src)
      c_IMM_I: imm = {{20{i[31]}}, i[31:20]};
      c_IMM_S: imm = {{20{i[31]}}, i[31:25], i[11:7]};
      c_IMM_B: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      c_IMM_J: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      c_IMM_U: imm = {i[31:12], 12'd0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154a_rf.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154a_rf
// Description : 32x32 register file, two combinational read ports and one
//               write port at the clock edge; x0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154a_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_a1,
  input  logic [4:0]  i_a2,
  input  logic [4:0]  i_a3,
  input  logic        i_we3,
  input  logic [31:0] i_wd3,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_regs [0:31];

  // Clear everything on reset; writes to x0 are dropped so entry 0 stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (i_we3 && (i_a3 != 5'd0)) begin
      r_regs[i_a3] <= i_wd3;
    end
  end

  // Reads see the pre-write value when the same register is written this cycle.
  assign o_rd1 = (i_a1 == 5'd0) ? 32'd0 : r_regs[i_a1];
  assign o_rd2 = (i_a2 == 5'd0) ? 32'd0 : r_regs[i_a2];

endmodule
`default_nettype wire

// File: rtl/ucsbece154a_datapath.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154a_datapath
// Description : Multicycle RV32I datapath driven by the registered control
//               bus of the FSM controller. Holds PC/OldPC/IR/Data/A/B/ALUOut,
//               the register file, immediate extender and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154a_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite_i,
  input  logic        AdrSrc_i,
  input  logic        IRWrite_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  ALUSrcA_i,
  input  logic [1:0]  ALUSrcB_i,
  input  logic [1:0]  ResultSrc_i,
  input  logic [2:0]  ALUControl_i,
  input  logic [2:0]  ImmSrc_i,
  input  logic [31:0] ReadData_i,
  output logic [31:0] Adr_o,
  output logic [31:0] WriteData_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_o,
  output logic        zero_o
);
  import ucsbece154a_datapath_pkg::*;

  logic [31:0] r_pc, r_old_pc, r_instr, r_data, r_a, r_b, r_alu_out;
  logic [31:0] w_rd1, w_rd2, w_imm_ext, w_src_a, w_src_b, w_alu_result, w_result;

  ucsbece154a_rf u_rf (
    .clk   (clk),
    .reset (reset),
    .i_a1  (r_instr[19:15]),
    .i_a2  (r_instr[24:20]),
    .i_a3  (r_instr[11:7]),
    .i_we3 (RegWrite_i),
    .i_wd3 (w_result),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Architectural state with write enables: PC, and IR together with OldPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= PC_RESET;
      r_old_pc <= 32'd0;
      r_instr  <= 32'd0;
    end else begin
      if (PCWrite_i) r_pc <= w_result;
      if (IRWrite_i) begin
        r_instr  <= ReadData_i;
        r_old_pc <= r_pc;
      end
    end
  end

  // Pipeline-style holding registers that load every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
    end else begin
      r_data    <= ReadData_i;
      r_a       <= w_rd1;
      r_b       <= w_rd2;
      r_alu_out <= w_alu_result;
    end
  end

  assign w_imm_ext = imm_extend(r_instr[31:7], ImmSrc_i);

  // Operand selection, ALU and result mux.
  always_comb begin
    w_src_a      = 32'd0;
    w_src_b      = 32'd0;
    w_alu_result = 32'd0;
    w_result     = 32'd0;
    case (ALUSrcA_i)
      c_SRCA_PC:    w_src_a = r_pc;
      c_SRCA_OLDPC: w_src_a = r_old_pc;
      c_SRCA_A:     w_src_a = r_a;
      default:      w_src_a = 32'd0;
    endcase
    case (ALUSrcB_i)
      c_SRCB_B:    w_src_b = r_b;
      c_SRCB_IMM:  w_src_b = w_imm_ext;
      c_SRCB_FOUR: w_src_b = 32'd4;
      default:     w_src_b = 32'd0;
    endcase
    case (ALUControl_i)
      c_ALU_ADD: w_alu_result = w_src_a + w_src_b;
      c_ALU_SUB: w_alu_result = w_src_a - w_src_b;
      c_ALU_AND: w_alu_result = w_src_a & w_src_b;
      c_ALU_OR:  w_alu_result = w_src_a | w_src_b;
      c_ALU_SLT: w_alu_result = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      default:   w_alu_result = 32'd0;
    endcase
    case (ResultSrc_i)
      c_RES_ALUOUT: w_result = r_alu_out;
      c_RES_DATA:   w_result = r_data;
      c_RES_ALURES: w_result = w_alu_result;
      default:      w_result = w_imm_ext;
    endcase
  end

  assign Adr_o       = AdrSrc_i ? w_result : r_pc;
  assign WriteData_o = r_b;
  assign op_o        = r_instr[6:0];
  assign funct3_o    = r_instr[14:12];
  assign funct7_o    = r_instr[30];
  assign zero_o      = (w_alu_result == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154a_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece154a_datapath
// Description : Self-checking bench for the multicycle datapath; drives the
//               control bus cycle by cycle and scores outputs against a queue
//               of expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece154a_datapath;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b101;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [1:0] SA_PC = 2'b00, SA_OLD = 2'b01, SA_A = 2'b10;
  localparam logic [1:0] SB_B = 2'b00, SB_IMM = 2'b01, SB_FOUR = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00, RS_DATA = 2'b01, RS_ALURES = 2'b10, RS_IMM = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite_i, AdrSrc_i, IRWrite_i, RegWrite_i;
  logic [1:0]  ALUSrcA_i, ALUSrcB_i, ResultSrc_i;
  logic [2:0]  ALUControl_i, ImmSrc_i;
  logic [31:0] ReadData_i = 32'd0;
  logic [31:0] Adr_o, WriteData_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_o, zero_o;

  ucsbece154a_datapath #(.PC_RESET(32'h100)) dut (
    .clk(clk), .reset(reset),
    .PCWrite_i(PCWrite_i), .AdrSrc_i(AdrSrc_i), .IRWrite_i(IRWrite_i), .RegWrite_i(RegWrite_i),
    .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i), .ResultSrc_i(ResultSrc_i),
    .ALUControl_i(ALUControl_i), .ImmSrc_i(ImmSrc_i), .ReadData_i(ReadData_i),
    .Adr_o(Adr_o), .WriteData_o(WriteData_o), .op_o(op_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_pc;

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    sb_t e;
    if (sbq.size() == 0) begin
      e.tag = "sb_empty";
      e.exp = ~obs;
    end else begin
      e = sbq.pop_front();
    end
    check_val(e.tag, obs, e.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic pcw, input logic adrs, input logic irw, input logic rw,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                         input logic [2:0] alu, input logic [2:0] imm);
    PCWrite_i = pcw; AdrSrc_i = adrs; IRWrite_i = irw; RegWrite_i = rw;
    ALUSrcA_i = sa; ALUSrcB_i = sb; ResultSrc_i = rs; ALUControl_i = alu; ImmSrc_i = imm;
  endtask

  task automatic ctl_idle();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, SA_PC, SB_B, RS_ALUOUT, ALU_ADD, IMM_I);
  endtask

  // Fetch cycle then one decode cycle (A/B load from the new instruction).
  task automatic do_fetch(input logic [31:0] ins);
    ReadData_i = ins;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, SA_PC, SB_FOUR, RS_ALURES, ALU_ADD, IMM_I);
    #1;
    sb_push("fetch_adr", m_pc);
    sb_pop_check(Adr_o);
    tick();
    m_pc = m_pc + 32'd4;
    ReadData_i = 32'd0;
    ctl_idle();
    #1;
    sb_push("pc_plus4", m_pc);
    sb_push("op", {25'd0, ins[6:0]});
    sb_push("funct3", {29'd0, ins[14:12]});
    sb_push("funct7", {31'd0, ins[30]});
    sb_pop_check(Adr_o);
    sb_pop_check({25'd0, op_o});
    sb_pop_check({29'd0, funct3_o});
    sb_pop_check({31'd0, funct7_o});
    tick();
  endtask

  // One ALU cycle observed through Result on Adr_o, plus zero flag.
  task automatic alu_obs(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [2:0] alu, input logic [31:0] exp_res, input logic exp_zero);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, sa, sb, RS_ALURES, alu, IMM_I);
    #1;
    sb_push(tag, exp_res);
    sb_push({tag, "_zero"}, {31'd0, exp_zero});
    sb_pop_check(Adr_o);
    sb_pop_check({31'd0, zero_o});
    tick();
  endtask

  task automatic imm_obs(input string tag, input logic [2:0] imm, input logic [31:0] exp);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, SA_PC, SB_B, RS_IMM, ALU_ADD, imm);
    #1;
    sb_push(tag, exp);
    sb_pop_check(Adr_o);
    tick();
  endtask

  // lw rd, 0x40(x0) with memory returning value.
  task automatic do_load(input logic [4:0] rd, input logic [31:0] value);
    do_fetch({12'h040, 5'd0, 3'b010, rd, 7'b0000011});
    alu_obs("lw_adr", SA_A, SB_IMM, ALU_ADD, 32'h40, 1'b0);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, SA_PC, SB_B, RS_ALUOUT, ALU_ADD, IMM_I);
    ReadData_i = value;
    #1;
    sb_push("lw_memadr", 32'h40);
    sb_pop_check(Adr_o);
    tick();
    ReadData_i = 32'd0;
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, SA_PC, SB_B, RS_DATA, ALU_ADD, IMM_I);
    #1;
    sb_push("lw_data", value);
    sb_pop_check(Adr_o);
    tick();
    ctl_idle();
  endtask

  task automatic check_reset_state(input string tag);
    ctl_idle();
    #1;
    sb_push({tag, "_adr"}, 32'h100);
    sb_push({tag, "_op"}, 32'd0);
    sb_push({tag, "_wd"}, 32'd0);
    sb_pop_check(Adr_o);
    sb_pop_check({25'd0, op_o});
    sb_pop_check(WriteData_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_pc = 32'h100;
    check_reset_state("rst");

    // addi x5,x0,5: rs2 field is 5, so B shows x5 after decode.
    do_fetch(32'h00500293);
    sb_push("x5_after_reset", 32'd0);
    sb_pop_check(WriteData_o);
    alu_obs("oldpc", SA_OLD, SB_B, ALU_ADD, 32'h100, 1'b0);
    alu_obs("pc_now", SA_PC, SB_B, ALU_ADD, 32'h104, 1'b0);
    alu_obs("addi_exec", SA_A, SB_IMM, ALU_ADD, 32'd5, 1'b0);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, SA_PC, SB_B, RS_ALUOUT, ALU_ADD, IMM_I);
    #1;
    sb_push("addi_wb", 32'd5);
    sb_pop_check(Adr_o);
    tick();
    ctl_idle();
    #1;
    sb_push("b_old_value", 32'd0);
    sb_pop_check(WriteData_o);
    tick();
    sb_push("b_new_value", 32'd5);
    sb_pop_check(WriteData_o);

    // addi x0,x0,5: write must be dropped.
    do_fetch(32'h00500013);
    alu_obs("x0_exec", SA_A, SB_IMM, ALU_ADD, 32'd5, 1'b0);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, SA_PC, SB_B, RS_ALUOUT, ALU_ADD, IMM_I);
    tick();
    ctl_idle();
    tick();
    alu_obs("x0_stays0", SA_A, SB_FOUR, ALU_ADD, 32'd4, 1'b0);

    // beq x5,x5,+8
    do_fetch(32'h00528463);
    alu_obs("beq_sub", SA_A, SB_B, ALU_SUB, 32'd0, 1'b1);
    imm_obs("imm_b", IMM_B, 32'd8);

    do_load(5'd6, 32'hDEADBEEF);

    // ALU ops on x6=3, x7=5 via sub x8,x6,x7
    do_load(5'd6, 32'd3);
    do_load(5'd7, 32'd5);
    do_fetch(32'h40730433);
    alu_obs("add_3_5", SA_A, SB_B, ALU_ADD, 32'd8, 1'b0);
    alu_obs("sub_3_5", SA_A, SB_B, ALU_SUB, 32'hFFFFFFFE, 1'b0);
    alu_obs("and_3_5", SA_A, SB_B, ALU_AND, 32'd1, 1'b0);
    alu_obs("or_3_5", SA_A, SB_B, ALU_OR, 32'd7, 1'b0);
    alu_obs("slt_3_5", SA_A, SB_B, ALU_SLT, 32'd1, 1'b0);
    alu_obs("alu_undef", SA_A, SB_B, 3'b111, 32'd0, 1'b1);
    imm_obs("imm_i", IMM_I, 32'h00000407);
    imm_obs("imm_s", IMM_S, 32'h00000408);
    imm_obs("imm_undef", 3'b101, 32'd0);

    // Signed compare: -1 < 1
    do_load(5'd6, 32'hFFFFFFFF);
    do_load(5'd7, 32'd1);
    do_fetch(32'h40730433);
    alu_obs("slt_m1_1", SA_A, SB_B, ALU_SLT, 32'd1, 1'b0);
    alu_obs("slt_m1_1_ab", SA_A, SB_FOUR, ALU_SLT, 32'd1, 1'b0);

    // jal x1,-4
    do_fetch(32'hFFDFF0EF);
    imm_obs("imm_j", IMM_J, 32'hFFFFFFFC);

    // lui x5,0x12345
    do_fetch(32'h123452B7);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, SA_PC, SB_B, RS_IMM, ALU_ADD, IMM_U);
    #1;
    sb_push("lui_wb", 32'h12345000);
    sb_pop_check(Adr_o);
    tick();
    do_fetch(32'h00528463);
    sb_push("x5_lui", 32'h12345000);
    sb_pop_check(WriteData_o);

    // Reset in the middle of an execute cycle with enables asserted.
    do_fetch(32'h00500293);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, SA_A, SB_IMM, RS_ALURES, ALU_ADD, IMM_I);
    ReadData_i = 32'hFFFFFFFF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ReadData_i = 32'd0;
    m_pc = 32'h100;
    check_reset_state("midrst");
    tick();
    do_fetch(32'h00500293);
    sb_push("x5_after_midrst", 32'd0);
    sb_pop_check(WriteData_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
